// File: rtl/alu_muldiv_seq_if.sv
// Bus between the control unit, the multiply/divide sequencer and the shared ALU.
// The sequencer takes the slave view; the control unit / ALU side takes the master view.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic             i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;
    logic [3:0]       o_alu_opcode;
    logic [1:0]       o_alu_extra;
    logic [WIDTH-1:0] o_alu_data1;
    logic [WIDTH-1:0] o_alu_data2;
    logic [WIDTH-1:0] i_alu_data;

    modport slave (
        input  i_start, i_op, i_a, i_b, i_alu_data,
        output o_busy, o_done, o_result, o_remainder, o_div_zero,
               o_alu_opcode, o_alu_extra, o_alu_data1, o_alu_data2
    );

    modport master (
        output i_start, i_op, i_a, i_b, i_alu_data,
        input  o_busy, o_done, o_result, o_remainder, o_div_zero,
               o_alu_opcode, o_alu_extra, o_alu_data1, o_alu_data2
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer issuing one ADD or SUB per cycle
// on the shared datapath ALU, with a start/done handshake to the control unit.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_muldiv_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_MOVE = 4'hD;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;        // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] b_q, b_d;        // multiplier, or divisor
    logic [WIDTH-1:0] acc_q, acc_d;    // product accumulator, or partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   r17_s;
    logic             ge_s;
    logic             last_s;

    // Bit 16 of the shifted remainder means it already exceeds any 16-bit divisor.
    assign r17_s  = {acc_q, a_q[WIDTH-1]};
    assign ge_s   = r17_s[WIDTH] | (r17_s[WIDTH-1:0] >= b_q);
    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = (bus.i_op && (bus.i_b == '0)) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN:   state_d = last_s ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive: MOVE with zero operands except while iterating
    always_comb begin
        bus.o_alu_opcode = ALU_MOVE;
        bus.o_alu_extra  = 2'b00;
        bus.o_alu_data1  = '0;
        bus.o_alu_data2  = '0;
        case (state_q)
            S_RUN: begin
                if (!op_q) begin
                    bus.o_alu_opcode = ALU_ADD;
                    bus.o_alu_data1  = acc_q;
                    bus.o_alu_data2  = b_q[0] ? a_q : '0;
                end else begin
                    bus.o_alu_opcode = ALU_SUB;
                    bus.o_alu_data1  = r17_s[WIDTH-1:0];
                    bus.o_alu_data2  = b_q;
                end
            end
            default: bus.o_alu_opcode = ALU_MOVE;
        endcase
    end

    // Datapath next-state: operand latch, per-iteration update, result capture
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    op_d  = bus.i_op;
                    a_d   = bus.i_a;
                    b_d   = bus.i_b;
                    acc_d = '0;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (bus.i_op && (bus.i_b == '0)) begin
                        result_d = '1;
                        rem_d    = bus.i_a;
                        dz_d     = 1'b1;
                    end else begin
                        dz_d     = 1'b0;
                    end
                end else begin
                    dz_d = dz_q;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q) begin
                    acc_d = bus.i_alu_data;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = ge_s ? bus.i_alu_data : r17_s[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], ge_s};
                end
                if (last_s) begin
                    result_d = op_q ? a_d : acc_d;
                    rem_d    = op_q ? acc_d : '0;
                end else begin
                    result_d = result_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            busy_q   <= (state_q != S_IDLE);
            done_q   <= (state_q == S_DONE);
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_result    = result_q;
    assign bus.o_remainder = rem_q;
    assign bus.o_div_zero  = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vector table, random ops against an arithmetic
// model, and hand sequences for held start, divide by zero and mid-operation reset.
module tb_alu_muldiv_seq;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_MOVE = 4'hD;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic [15:0] alu_s;

    alu_muldiv_seq_if #(.WIDTH(16)) bus ();

    alu_muldiv_seq #(.WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU seen by the sequencer
    always_comb begin
        case (bus.o_alu_opcode)
            ALU_ADD: alu_s = bus.o_alu_data1 + bus.o_alu_data2;
            ALU_SUB: alu_s = bus.o_alu_data1 - bus.o_alu_data2;
            default: alu_s = bus.o_alu_data2;
        endcase
    end
    assign bus.i_alu_data = alu_s;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] rem;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_model(input logic op, input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] res, output logic [15:0] rem,
                             output logic dz);
        int unsigned p;
        if (!op) begin
            p   = a * b;
            res = p[15:0];
            rem = 16'h0000;
            dz  = 1'b0;
        end else if (b == 16'h0000) begin
            res = 16'hFFFF;
            rem = a;
            dz  = 1'b1;
        end else begin
            res = a / b;
            rem = a % b;
            dz  = 1'b0;
        end
    endtask

    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [15:0] rem,
                          output logic dz, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_op    = 1'($urandom);
        bus.i_a     = 16'($urandom);
        bus.i_b     = 16'($urandom);
        lat      = -1;
        busy_cnt = 0;
        res = 16'h0; rem = 16'h0; dz = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) busy_cnt++;
            if (bus.o_done) begin
                lat = k;
                res = bus.o_result;
                rem = bus.o_remainder;
                dz  = bus.o_div_zero;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic op,
                                 input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er, em, ar, am;
        logic        ed, ad;
        int          lat, bc, elat;
        ref_model(op, a, b, er, em, ed);
        elat = (op && b == 16'h0) ? 1 : 17;
        run_op(op, a, b, ar, am, ad, lat, bc);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(bc), 32'(elat));
        check({tag, " result"}, {16'h0, ar}, {16'h0, er});
        check({tag, " remainder"}, {16'h0, am}, {16'h0, em});
        check({tag, " div_zero"}, {31'h0, ad}, {31'h0, ed});
    endtask

    initial begin
        vec_t vecs [8];
        logic [15:0] ra, rb;
        logic        rop;
        int          ndone;

        n_checks = 0;
        n_err    = 0;
        vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h1234, 16'h0100, 16'h3400, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        vecs[6] = '{1'b1, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 1'b1};
        vecs[7] = '{1'b0, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 1'b0};

        bus.i_start = 1'b0;
        bus.i_op    = 1'b0;
        bus.i_a     = 16'h0;
        bus.i_b     = 16'h0;
        rst_n       = 1'b0;
        #12;
        check("reset busy", {31'h0, bus.o_busy}, 32'h0);
        check("reset done", {31'h0, bus.o_done}, 32'h0);
        check("reset result", {16'h0, bus.o_result}, 32'h0);
        check("reset remainder", {16'h0, bus.o_remainder}, 32'h0);
        check("reset div_zero", {31'h0, bus.o_div_zero}, 32'h0);
        check("reset alu opcode", {28'h0, bus.o_alu_opcode}, {28'h0, ALU_MOVE});
        check("reset alu data", {bus.o_alu_data1, bus.o_alu_data2}, 32'h0);
        check("reset alu extra", {30'h0, bus.o_alu_extra}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d table result", i), {16'h0, bus.o_result}, {16'h0, vecs[i].res});
            check($sformatf("vec%0d table remainder", i), {16'h0, bus.o_remainder}, {16'h0, vecs[i].rem});
            check($sformatf("vec%0d table div_zero", i), {31'h0, bus.o_div_zero}, {31'h0, vecs[i].dz});
        end

        for (int i = 0; i < 30; i++) begin
            rop = 1'($urandom);
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 16'h00FF;
            run_and_check($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Start held high with changing operands: accepts at edge 0 and edge 18 only
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = 1'b0;
        bus.i_a     = 16'h0003;
        bus.i_b     = 16'h0005;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int k = 1; k <= 35; k++) begin
            if (k == 18) begin
                bus.i_a = 16'h0007;
                bus.i_b = 16'h0009;
            end else begin
                bus.i_a = 16'($urandom);
                bus.i_b = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (bus.o_done) ndone++;
            if (k == 17) begin
                check("held start first done", {31'h0, bus.o_done}, 32'h1);
                check("held start first result", {16'h0, bus.o_result}, 32'h000F);
            end
            if (k == 18) check("held start no done in idle", {31'h0, bus.o_done}, 32'h0);
            if (k == 35) begin
                check("held start second done", {31'h0, bus.o_done}, 32'h1);
                check("held start second result", {16'h0, bus.o_result}, 32'h003F);
            end
        end
        bus.i_start = 1'b0;
        check("held start done count", 32'(ndone), 32'd2);

        // Reset in cycle 8 of a divide aborts with no done pulse
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = 1'b1;
        bus.i_a     = 16'h1234;
        bus.i_b     = 16'h0007;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int k = 1; k <= 8; k++) @(posedge clk);
        #1;
        check("mid busy before reset", {31'h0, bus.o_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'h0, bus.o_busy}, 32'h0);
        check("mid reset done", {31'h0, bus.o_done}, 32'h0);
        check("mid reset result", {16'h0, bus.o_result}, 32'h0);
        check("mid reset remainder", {16'h0, bus.o_remainder}, 32'h0);
        check("mid reset alu opcode", {28'h0, bus.o_alu_opcode}, {28'h0, ALU_MOVE});
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done || bus.o_busy) ndone++;
        end
        check("mid reset no activity", 32'(ndone), 32'd0);
        run_and_check("after reset div", 1'b1, 16'd1000, 16'd33);
        run_and_check("after reset mul", 1'b0, 16'h00FF, 16'h0101);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that computes 16x16 unsigned multiply (low 16 bits) and 16/16 unsigned divide. Each iteration issues one ADD or SUB on the shared 16-bit ALU. Sits beside the ALU in the CPU datapath. It drives the ALU opcode, extra and operand inputs and reads the ALU result back combinationally, with a start/done handshake toward the control unit.

Parameters:
WIDTH, 16, operand/result width; the iteration count equals WIDTH.

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request; sampled only in IDLE
i_op  input  1  0 = multiply, 1 = divide
i_a  input  WIDTH  multiplicand / dividend
i_b  input  WIDTH  multiplier / divisor
o_busy  output  1  high while state != IDLE
o_done  output  1  one-cycle pulse, result valid
o_result  output  WIDTH  product low bits / quotient
o_remainder  output  WIDTH  remainder (divide); 0 for multiply
o_div_zero  output  1  set on divide with i_b == 0
o_alu_opcode  output  4  opcode to ALU (ADD/SUB/MOVE encodings from opcodes.vh)
o_alu_extra  output  2  always 2'b00
o_alu_data1  output  WIDTH  ALU operand 1
o_alu_data2  output  WIDTH  ALU operand 2
i_alu_data  input  WIDTH  ALU result, combinational from current o_alu_* values

Behaviour:
- One clock domain. i_rst_n low asynchronously forces: state IDLE, every output register 0, counter 0. o_alu_opcode reads MOVE, o_alu_data* 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU driven MOVE with zero operands.
  - On i_start = 1, latch a, b and op; clear acc/rem and o_div_zero; cnt = 0.
  - Next state is RUN, or DONE if op = divide and i_b = 0.
- RUN, multiply (one iteration per cycle):
  - ALU = ADD(acc, b[0] ? a : 0).
  - Clock edge: acc <= i_alu_data; a <<= 1; b >>= 1; cnt++.
- RUN, divide (restoring):
  - r17 = {rem, dividend[MSB]} (17 bits, held locally).
  - ALU = SUB(r17[15:0], divisor).
  - ge = r17[16] | (r17[15:0] >= divisor).
  - Clock edge: if ge, rem <= i_alu_data (wraps correctly when r17[16] = 1), else rem <= r17[15:0]. dividend <= {dividend[MSB-1:0], ge}; cnt++.
- After the WIDTH-th iteration (cnt = WIDTH-1 at the edge), go to DONE.
- DONE (one cycle):
  - o_done = 1. o_result / o_remainder updated at the DONE-entry edge.
  - Next state IDLE unconditionally.
  - i_start in DONE is ignored; the earliest new accept is the following IDLE cycle.
- Divide by zero: goes to DONE the cycle after accept. o_result = 0xFFFF, o_remainder = i_a, o_div_zero = 1.
- Latency, with the accept edge as edge 0:
  - Normal op: o_done high after edge WIDTH+1, i.e. edge 17 for WIDTH = 16.
  - Divide by zero: o_done high after edge 1.
- o_result, o_remainder and o_div_zero hold until the next accepted start. o_div_zero clears on that accept.
- o_busy = (state != IDLE), registered from state.
- i_start while busy is ignored; no queueing.
- Inputs i_a, i_b and i_op may change after the accept without effect.
- Reset mid-operation aborts. No o_done pulse; outputs return to reset values.
- Multiply overflow above WIDTH bits is discarded silently; no flag.

Test Plan:
- Mul 0x0003 x 0x0005, start at edge 0 -> o_busy high edges 1..17. o_done pulses after edge 17; o_result 0x000F, o_remainder 0.
- Mul 0x1234 x 0x0100 -> o_result 0x3400. Mul 0xFFFF x 0xFFFF -> o_result 0x0001.
- Div 100 / 7 -> o_result 14, o_remainder 2. Div 0xFFFF / 0x0001 -> 0xFFFF r 0. Div 0x8000 / 0xFFFF -> 0 r 0x8000, exercising the r17[16] path.
- Div 0x0042 / 0 -> o_done after edge 1 of 2; o_result 0xFFFF, o_remainder 0x0042, o_div_zero 1. The next mul clears o_div_zero.
- i_start held high through a multiply with changing operands -> only the first request executes. A second accept occurs in the IDLE cycle after DONE.
- Assert i_rst_n low at cycle 8 of a divide -> o_busy, o_done and outputs 0 immediately. No done pulse; a new op afterwards is correct.
